b2b_evt_read_sequencer: RTL and testbench
=========================================

Name: b2b_evt_read_sequencer

Overview:
Downstream consumer of the b2b FIFO-selection stage. It keeps one event counter per cluster FIFO and drives `evt_available` back to the selector. It then takes the selected `fifo_idx`, pops one complete event (up to and including its end-of-event word) from that first-word-fall-through (FWFT) FIFO onto a single valid/ready output link, and re-arbitrates after a fixed gap. This gap lets the registered rd-count grouping settle before the next selection.

Parameters:
TOTAL_CLUSTERS, 4, number of cluster FIFOs served.
DATA_W, 64, FIFO/output data word width.
IDX_W, $clog2(TOTAL_CLUSTERS)+1, width of `fifo_idx`; value TOTAL_CLUSTERS means "no FIFO selected".
EVT_CNT_W, 8, width of the per-FIFO complete-event counter.
ARB_GAP, 2, idle cycles after end-of-event before `fifo_idx` is sampled again (range 1..15).
MAX_EVT_WORDS, 1024, word-count limit that flags an overlong event.

Ports:
clk  in  1  single clock.
rst  in  1  asynchronous, active-high reset.
fifo_idx  in  IDX_W  selected FIFO from the selection stage; TOTAL_CLUSTERS or larger = none.
fifo_wr_eoe  in  TOTAL_CLUSTERS  1-cycle pulse per FIFO when an end-of-event word is written into it.
fifo_empty  in  TOTAL_CLUSTERS  per-FIFO empty flag (FWFT).
fifo_dout  in  DATA_W x [TOTAL_CLUSTERS]  per-FIFO head word (valid when not empty).
fifo_eoe  in  TOTAL_CLUSTERS  per-FIFO head-word end-of-event flag.
fifo_rd_en  out  TOTAL_CLUSTERS  per-FIFO pop strobe (one-hot or zero).
evt_available  out  TOTAL_CLUSTERS  per-FIFO flag: at least one complete event is stored.
out_data  out  DATA_W  output word.
out_last  out  1  output word is end-of-event.
out_valid  out  1  output word valid.
out_ready  in  1  downstream accept.
busy  out  1  high in any state other than IDLE.
cur_idx  out  IDX_W  latched FIFO index; TOTAL_CLUSTERS when idle.
err_long_evt  out  1  sticky: an event exceeded MAX_EVT_WORDS words.

Behaviour:
- Reset (asynchronous, immediate), all outputs and state:
  - All event counters = 0, so `evt_available` = 0.
  - `fifo_rd_en` = 0, `out_valid` = 0, `out_last` = 0, `out_data` = 0.
  - State = IDLE, `cur_idx` = TOTAL_CLUSTERS, `busy` = 0, `err_long_evt` = 0, word count = 0.
  - A reset mid-event abandons the event; there is no recovery of partial state.
- Event counter i:
  - +1 on `fifo_wr_eoe[i]`.
  - −1 on a pop of FIFO i while `fifo_eoe[i]` = 1.
  - Both in the same cycle: unchanged.
  - Saturates at 2^EVT_CNT_W − 1 on increment; never decrements below 0.
  - `evt_available[i]` = (counter i ≠ 0), driven combinationally from the register.
- FSM states: IDLE, STREAM, GAP.
- IDLE:
  - Transition condition: `fifo_idx` < TOTAL_CLUSTERS and `evt_available[fifo_idx]` = 1.
  - On that condition: latch `cur_idx` = `fifo_idx`, clear word count, go to STREAM the next cycle.
  - Otherwise stay in IDLE; stale or out-of-range indices are ignored.
- STREAM, pop condition:
  - pop = !`fifo_empty[cur_idx]` && (!`out_valid` || `out_ready`).
  - `fifo_rd_en[cur_idx]` = pop, combinational; the `out_ready`→`rd_en` path is allowed.
- STREAM, on pop:
  - `out_data` <= `fifo_dout[cur_idx]`, `out_last` <= `fifo_eoe[cur_idx]`, `out_valid` <= 1.
  - Word count +1, saturating.
- STREAM, output handshake:
  - `out_valid` clears when `out_ready` && no pop.
  - Output holds stable while `out_valid` && !`out_ready`.
- STREAM, end of event:
  - A pop with `fifo_eoe` = 1 moves the FSM to GAP next cycle.
  - No further pops of that FIFO in the same event.
- STREAM, empty FIFO mid-event: stall with no pops and stay in STREAM.
- STREAM, long event: when word count reaches MAX_EVT_WORDS with no eoe, set `err_long_evt` (sticky until reset) and keep streaming.
- GAP:
  - `fifo_rd_en` = 0; the output register may still drain.
  - Stay exactly ARB_GAP cycles, then go to IDLE with `cur_idx` = TOTAL_CLUSTERS.
- Latency:
  - `fifo_idx` sample → first pop: 1 cycle.
  - Pop → `out_valid`: 1 cycle.
  - Sustained throughput: 1 word/cycle while `out_ready` = 1 and the FIFO is non-empty.
- Only one FIFO is read per event; events are never interleaved on the output.

Test Plan:
- Single event, no backpressure:
  - Stimulus: FIFO 2 holds 3 words (eoe on the 3rd), one `fifo_wr_eoe[2]` pulse, `fifo_idx` = 2, `out_ready` = 1.
  - Response: 3 consecutive `out_valid` beats, `out_last` on beat 3, `evt_available[2]` 1→0, `busy` low 2 cycles after GAP.
- Backpressure:
  - Stimulus: same event with `out_ready` toggling 1,0,0,1,1.
  - Response: `out_data` stable while stalled, `fifo_rd_en[2]` = 0 during stall cycles, no word lost or duplicated.
- No selection:
  - Stimulus: `fifo_idx` = TOTAL_CLUSTERS, or `fifo_idx` = 1 with `evt_available[1]` = 0.
  - Response: stays IDLE, `fifo_rd_en` = 0.
- Counter edges:
  - Stimulus: simultaneous `fifo_wr_eoe[0]` and an eoe pop of FIFO 0 with counter = 1.
  - Response: counter stays 1. Separately, 256 pulses with EVT_CNT_W = 8 → counter saturates at 255.
- Underflow mid-event and long event:
  - Stimulus: FIFO empties after word 2 of an event, then refills; then a 1025-word event with no eoe.
  - Response: STREAM stalls then resumes without leaving STREAM; `err_long_evt` sets at word 1024.
- Reset mid-STREAM:
  - Stimulus: assert `rst` asynchronously between clock edges.
  - Response: `out_valid`, `fifo_rd_en`, `busy` = 0 and `cur_idx` = TOTAL_CLUSTERS immediately, before the next edge; all counters = 0.

Source files
------------

// File: rtl/b2b_evt_read_sequencer_if.sv
// Handshake/bus bundle between the b2b FIFO-selection stage, the cluster FIFOs,
// the event read sequencer and the downstream valid/ready link.
interface b2b_evt_read_sequencer_if #(
   parameter int TOTAL_CLUSTERS = 4,
   parameter int DATA_W         = 64,
   parameter int IDX_W          = $clog2(TOTAL_CLUSTERS) + 1
);
   logic [IDX_W-1:0]                       fifo_idx;
   logic [TOTAL_CLUSTERS-1:0]              fifo_wr_eoe;
   logic [TOTAL_CLUSTERS-1:0]              fifo_empty;
   logic [TOTAL_CLUSTERS-1:0][DATA_W-1:0]  fifo_dout;
   logic [TOTAL_CLUSTERS-1:0]              fifo_eoe;
   logic [TOTAL_CLUSTERS-1:0]              fifo_rd_en;
   logic [TOTAL_CLUSTERS-1:0]              evt_available;
   logic [DATA_W-1:0]                      out_data;
   logic                                   out_last;
   logic                                   out_valid;
   logic                                   out_ready;
   logic                                   busy;
   logic [IDX_W-1:0]                       cur_idx;
   logic                                   err_long_evt;

   modport master (
      output fifo_idx, fifo_wr_eoe, fifo_empty, fifo_dout, fifo_eoe, out_ready,
      input  fifo_rd_en, evt_available, out_data, out_last, out_valid, busy,
             cur_idx, err_long_evt
   );

   modport slave (
      input  fifo_idx, fifo_wr_eoe, fifo_empty, fifo_dout, fifo_eoe, out_ready,
      output fifo_rd_en, evt_available, out_data, out_last, out_valid, busy,
             cur_idx, err_long_evt
   );
endinterface

// File: rtl/b2b_evt_read_sequencer.sv
// Pops one complete event from the selected FWFT cluster FIFO onto a valid/ready
// link, tracks complete events per FIFO, and waits a fixed gap before re-arbitrating.
module b2b_evt_read_sequencer #(
   parameter int TOTAL_CLUSTERS = 4,
   parameter int DATA_W         = 64,
   parameter int IDX_W          = $clog2(TOTAL_CLUSTERS) + 1,
   parameter int EVT_CNT_W      = 8,
   parameter int ARB_GAP        = 2,
   parameter int MAX_EVT_WORDS  = 1024
) (
   input logic                   clk,
   input logic                   rst,
   b2b_evt_read_sequencer_if.slave bus
);

   localparam int WC_W  = $clog2(MAX_EVT_WORDS + 1);
   localparam int GAP_W = 4;
   localparam logic [IDX_W-1:0]     IDX_NONE = IDX_W'(TOTAL_CLUSTERS);
   localparam logic [EVT_CNT_W-1:0] CNT_MAX  = {EVT_CNT_W{1'b1}};
   localparam logic [WC_W-1:0]      WC_SAT   = {WC_W{1'b1}};
   localparam logic [WC_W-1:0]      WC_LAST  = WC_W'(MAX_EVT_WORDS - 1);
   localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(ARB_GAP - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2
   } state_t;

   state_t                    state_r;
   logic [IDX_W-1:0]          cur_idx_r;
   logic                      busy_r;
   logic [DATA_W-1:0]         out_data_r;
   logic                      out_last_r;
   logic                      out_valid_r;
   logic                      err_long_evt_r;
   logic [WC_W-1:0]           wc_r;
   logic [GAP_W-1:0]          gap_r;
   logic [EVT_CNT_W-1:0]      evt_cnt_r [TOTAL_CLUSTERS];

   logic [TOTAL_CLUSTERS-1:0] evt_available_s;
   logic [TOTAL_CLUSTERS-1:0] rd_en_s;
   logic                      sel_ok_s;
   logic                      cur_empty_s;
   logic [DATA_W-1:0]         cur_dout_s;
   logic                      cur_eoe_s;
   logic                      pop_s;

   // Head-word mux for the latched FIFO, selection qualification and pop strobe
   always_comb begin
      sel_ok_s    = 1'b0;
      cur_empty_s = 1'b1;
      cur_dout_s  = '0;
      cur_eoe_s   = 1'b0;
      rd_en_s     = '0;
      for (int i = 0; i < TOTAL_CLUSTERS; i++) begin
         evt_available_s[i] = (evt_cnt_r[i] != '0);
         sel_ok_s    = sel_ok_s | ((bus.fifo_idx == IDX_W'(i)) & evt_available_s[i]);
         cur_empty_s = cur_empty_s & ((cur_idx_r != IDX_W'(i)) | bus.fifo_empty[i]);
         cur_dout_s  = cur_dout_s | ({DATA_W{cur_idx_r == IDX_W'(i)}} & bus.fifo_dout[i]);
         cur_eoe_s   = cur_eoe_s | ((cur_idx_r == IDX_W'(i)) & bus.fifo_eoe[i]);
      end
      pop_s = (state_r == STREAM) && !cur_empty_s && (!out_valid_r || bus.out_ready);
      for (int i = 0; i < TOTAL_CLUSTERS; i++) begin
         rd_en_s[i] = pop_s && (cur_idx_r == IDX_W'(i));
      end
   end

   // Per-FIFO complete-event counters: written eoe increments, popped eoe decrements
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TOTAL_CLUSTERS; i++) begin
            evt_cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < TOTAL_CLUSTERS; i++) begin
            if (bus.fifo_wr_eoe[i] && !(rd_en_s[i] && bus.fifo_eoe[i])) begin
               if (evt_cnt_r[i] != CNT_MAX) begin
                  evt_cnt_r[i] <= evt_cnt_r[i] + EVT_CNT_W'(1);
               end else begin
                  evt_cnt_r[i] <= evt_cnt_r[i];
               end
            end else if (!bus.fifo_wr_eoe[i] && rd_en_s[i] && bus.fifo_eoe[i]) begin
               if (evt_cnt_r[i] != '0) begin
                  evt_cnt_r[i] <= evt_cnt_r[i] - EVT_CNT_W'(1);
               end else begin
                  evt_cnt_r[i] <= evt_cnt_r[i];
               end
            end else begin
               evt_cnt_r[i] <= evt_cnt_r[i];
            end
         end
      end
   end

   // Sequencer FSM with its registered output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= IDLE;
         cur_idx_r      <= IDX_NONE;
         busy_r         <= 1'b0;
         out_data_r     <= '0;
         out_last_r     <= 1'b0;
         out_valid_r    <= 1'b0;
         err_long_evt_r <= 1'b0;
         wc_r           <= '0;
         gap_r          <= '0;
      end else begin
         // The output register drains in every state, so a stalled last word survives GAP
         if (pop_s) begin
            out_data_r  <= cur_dout_s;
            out_last_r  <= cur_eoe_s;
            out_valid_r <= 1'b1;
         end else if (bus.out_ready) begin
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end

         case (state_r)
            IDLE: begin
               if (sel_ok_s) begin
                  state_r   <= STREAM;
                  cur_idx_r <= bus.fifo_idx;
                  busy_r    <= 1'b1;
                  wc_r      <= '0;
               end else begin
                  state_r <= IDLE;
               end
            end
            STREAM: begin
               if (pop_s) begin
                  if (wc_r != WC_SAT) begin
                     wc_r <= wc_r + WC_W'(1);
                  end else begin
                     wc_r <= wc_r;
                  end
                  if (cur_eoe_s) begin
                     state_r <= GAP;
                     gap_r   <= GAP_LOAD;
                  end else if (wc_r == WC_LAST) begin
                     err_long_evt_r <= 1'b1;
                  end else begin
                     state_r <= STREAM;
                  end
               end else begin
                  state_r <= STREAM;
               end
            end
            GAP: begin
               if (gap_r == '0) begin
                  state_r   <= IDLE;
                  cur_idx_r <= IDX_NONE;
                  busy_r    <= 1'b0;
               end else begin
                  gap_r <= gap_r - GAP_W'(1);
               end
            end
            default: begin
               state_r   <= IDLE;
               cur_idx_r <= IDX_NONE;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fifo_rd_en    = rd_en_s;
   assign bus.evt_available = evt_available_s;
   assign bus.out_data      = out_data_r;
   assign bus.out_last      = out_last_r;
   assign bus.out_valid     = out_valid_r;
   assign bus.busy          = busy_r;
   assign bus.cur_idx       = cur_idx_r;
   assign bus.err_long_evt  = err_long_evt_r;

endmodule

// File: tb/tb_b2b_evt_read_sequencer.sv
// Directed bench for b2b_evt_read_sequencer: FWFT FIFO model per cluster and
// per-scenario tasks with hand-computed expectations.
module tb_b2b_evt_read_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   b2b_evt_read_sequencer_if #(.TOTAL_CLUSTERS(4), .DATA_W(64), .IDX_W(3)) bus ();

   b2b_evt_read_sequencer #(
      .TOTAL_CLUSTERS(4), .DATA_W(64), .IDX_W(3), .EVT_CNT_W(8),
      .ARB_GAP(2), .MAX_EVT_WORDS(1024)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // FWFT FIFO model: {eoe, data} entries, popped on fifo_rd_en at the clock edge
   logic [64:0] mem [4][2048];
   logic [10:0] wr_ptr [4];
   logic [10:0] rd_ptr [4];
   logic [3:0]  fe;
   logic [3:0]  feoe;
   logic [3:0][63:0] fdout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) rd_ptr[i] <= 11'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (bus.fifo_rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 11'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         fe[i]    = (wr_ptr[i] == rd_ptr[i]);
         fdout[i] = mem[i][rd_ptr[i]][63:0];
         feoe[i]  = mem[i][rd_ptr[i]][64];
      end
   end

   assign bus.fifo_empty = fe;
   assign bus.fifo_dout  = fdout;
   assign bus.fifo_eoe   = feoe;

   task automatic push(input int f, input logic [63:0] d, input logic e);
      mem[f][wr_ptr[f]] = {e, d};
      wr_ptr[f] = wr_ptr[f] + 11'd1;
   endtask

   task automatic pulse_eoe(input int f);
      logic [3:0] m;
      m = 4'd0;
      m[f] = 1'b1;
      bus.fifo_wr_eoe = m;
      @(negedge clk);
      bus.fifo_wr_eoe = 4'd0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.fifo_idx    = 3'd4;
      bus.fifo_wr_eoe = 4'd0;
      bus.out_ready   = 1'b1;
      for (int i = 0; i < 4; i++) wr_ptr[i] = 11'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
      checks++; if (bus.out_last !== 1'b0 || bus.out_data !== 64'd0) begin failures++; $display("FAIL reset_out_word got last=%0b data=%0h exp 0/0", bus.out_last, bus.out_data); end
      checks++; if (bus.fifo_rd_en !== 4'd0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0000", bus.fifo_rd_en); end
      checks++; if (bus.evt_available !== 4'd0) begin failures++; $display("FAIL reset_evt_available got=%b exp=0000", bus.evt_available); end
      checks++; if (bus.busy !== 1'b0 || bus.cur_idx !== 3'd4) begin failures++; $display("FAIL reset_idle got busy=%0b cur_idx=%0d exp 0/4", bus.busy, bus.cur_idx); end
      checks++; if (bus.err_long_evt !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.err_long_evt); end
   endtask

   task automatic test_single_event();
      logic [63:0] w [3];
      w[0] = 64'hA000_0000_0000_0001;
      w[1] = 64'hA000_0000_0000_0002;
      w[2] = 64'hA000_0000_0000_0003;
      apply_reset();
      for (int k = 0; k < 3; k++) push(2, w[k], k == 2);
      pulse_eoe(2);
      checks++; if (bus.evt_available !== 4'b0100) begin failures++; $display("FAIL single_avail_set got=%b exp=0100", bus.evt_available); end
      bus.fifo_idx = 3'd2;
      @(negedge clk);
      bus.fifo_idx = 3'd4;
      checks++; if (bus.busy !== 1'b1 || bus.cur_idx !== 3'd2) begin failures++; $display("FAIL single_latch got busy=%0b cur_idx=%0d exp 1/2", bus.busy, bus.cur_idx); end
      checks++; if (bus.fifo_rd_en !== 4'b0100 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_first_pop got rd_en=%b valid=%0b exp 0100/0", bus.fifo_rd_en, bus.out_valid); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== w[k] || bus.out_last !== (k == 2)) begin
            failures++;
            $display("FAIL single_beat%0d got valid=%0b data=%0h last=%0b exp 1/%0h/%0b", k, bus.out_valid, bus.out_data, bus.out_last, w[k], k == 2);
         end
      end
      checks++; if (bus.evt_available !== 4'd0 || bus.fifo_rd_en !== 4'd0 || bus.busy !== 1'b1) begin failures++; $display("FAIL single_gap_entry got avail=%b rd_en=%b busy=%0b exp 0000/0000/1", bus.evt_available, bus.fifo_rd_en, bus.busy); end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL single_gap_hold got valid=%0b busy=%0b exp 0/1", bus.out_valid, bus.busy); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.cur_idx !== 3'd4) begin failures++; $display("FAIL single_back_idle got busy=%0b cur_idx=%0d exp 0/4", bus.busy, bus.cur_idx); end
   endtask

   task automatic test_backpressure();
      logic [63:0] w [3];
      logic [63:0] rx [8];
      int          rx_n;
      bit [6:0]    rdy_v;
      bit [6:0]    ev_v;
      bit [6:0]    er_v;
      int          ed [7];
      w[0] = 64'hB000_0000_0000_0010;
      w[1] = 64'hB000_0000_0000_0020;
      w[2] = 64'hB000_0000_0000_0030;
      rdy_v = 7'b1111001;
      ev_v  = 7'b0111110;
      er_v  = 7'b0011001;
      ed    = '{0, 0, 0, 0, 1, 2, 0};
      rx_n  = 0;
      apply_reset();
      for (int k = 0; k < 3; k++) push(2, w[k], k == 2);
      pulse_eoe(2);
      bus.fifo_idx = 3'd2;
      @(negedge clk);
      bus.fifo_idx = 3'd4;
      for (int c = 0; c < 7; c++) begin
         bus.out_ready = rdy_v[c];
         #1;
         checks++; if (bus.fifo_rd_en !== (er_v[c] ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL bp_rd_en_c%0d got=%b exp_pop=%0b", c, bus.fifo_rd_en, er_v[c]); end
         checks++; if (bus.out_valid !== ev_v[c]) begin failures++; $display("FAIL bp_valid_c%0d got=%0b exp=%0b", c, bus.out_valid, ev_v[c]); end
         if (ev_v[c]) begin
            checks++; if (bus.out_data !== w[ed[c]]) begin failures++; $display("FAIL bp_data_c%0d got=%0h exp=%0h", c, bus.out_data, w[ed[c]]); end
         end
         if (bus.out_valid && bus.out_ready && rx_n < 8) begin
            rx[rx_n] = bus.out_data;
            rx_n++;
         end
         @(negedge clk);
      end
      checks++; if (rx_n != 3) begin failures++; $display("FAIL bp_word_count got=%0d exp=3", rx_n); end
      for (int k = 0; k < 3 && k < rx_n; k++) begin
         checks++; if (rx[k] !== w[k]) begin failures++; $display("FAIL bp_rx%0d got=%0h exp=%0h", k, rx[k], w[k]); end
      end
   endtask

   task automatic test_no_selection();
      logic [2:0] idx_list [4];
      idx_list = '{3'd4, 3'd5, 3'd7, 3'd1};
      apply_reset();
      push(0, 64'h0000_0000_0000_00C0, 1'b1);
      pulse_eoe(0);
      push(1, 64'h0000_0000_0000_00C1, 1'b1);
      for (int n = 0; n < 4; n++) begin
         bus.fifo_idx = idx_list[n];
         @(negedge clk);
         @(negedge clk);
         checks++; if (bus.busy !== 1'b0 || bus.cur_idx !== 3'd4 || bus.fifo_rd_en !== 4'd0) begin failures++; $display("FAIL nosel_idx%0d got busy=%0b cur_idx=%0d rd_en=%b exp 0/4/0000", idx_list[n], bus.busy, bus.cur_idx, bus.fifo_rd_en); end
      end
      bus.fifo_idx = 3'd0;
      @(negedge clk);
      bus.fifo_idx = 3'd4;
      checks++; if (bus.busy !== 1'b1 || bus.cur_idx !== 3'd0) begin failures++; $display("FAIL nosel_valid_pick got busy=%0b cur_idx=%0d exp 1/0", bus.busy, bus.cur_idx); end
   endtask

   task automatic test_counter_edges();
      apply_reset();
      push(0, 64'h0000_0000_0000_0D00, 1'b1);
      pulse_eoe(0);
      checks++; if (dut.evt_cnt_r[0] !== 8'd1) begin failures++; $display("FAIL cnt_initial got=%0d exp=1", dut.evt_cnt_r[0]); end
      bus.fifo_idx = 3'd0;
      @(negedge clk);
      bus.fifo_idx = 3'd4;
      checks++; if (bus.fifo_rd_en !== 4'b0001) begin failures++; $display("FAIL cnt_pop_strobe got=%b exp=0001", bus.fifo_rd_en); end
      bus.fifo_wr_eoe = 4'b0001;
      push(0, 64'h0000_0000_0000_0D01, 1'b1);
      @(negedge clk);
      bus.fifo_wr_eoe = 4'd0;
      checks++; if (dut.evt_cnt_r[0] !== 8'd1 || bus.evt_available[0] !== 1'b1) begin failures++; $display("FAIL cnt_simultaneous got=%0d avail=%0b exp 1/1", dut.evt_cnt_r[0], bus.evt_available[0]); end
      checks++; if (bus.out_last !== 1'b1 || bus.out_data !== 64'h0000_0000_0000_0D00) begin failures++; $display("FAIL cnt_eoe_popped got last=%0b data=%0h exp 1/d00", bus.out_last, bus.out_data); end
      bus.fifo_wr_eoe = 4'b1000;
      repeat (255) @(negedge clk);
      checks++; if (dut.evt_cnt_r[3] !== 8'd255) begin failures++; $display("FAIL cnt_255 got=%0d exp=255", dut.evt_cnt_r[3]); end
      @(negedge clk);
      bus.fifo_wr_eoe = 4'd0;
      checks++; if (dut.evt_cnt_r[3] !== 8'd255 || bus.evt_available[3] !== 1'b1) begin failures++; $display("FAIL cnt_saturate got=%0d avail=%0b exp 255/1", dut.evt_cnt_r[3], bus.evt_available[3]); end
   endtask

   task automatic test_underflow();
      apply_reset();
      push(1, 64'h0000_0000_0000_0E00, 1'b0);
      push(1, 64'h0000_0000_0000_0E01, 1'b0);
      pulse_eoe(1);
      bus.fifo_idx = 3'd1;
      @(negedge clk);
      bus.fifo_idx = 3'd4;
      checks++; if (bus.fifo_rd_en !== 4'b0010) begin failures++; $display("FAIL uf_pop0 got=%b exp=0010", bus.fifo_rd_en); end
      @(negedge clk);
      checks++; if (bus.fifo_rd_en !== 4'b0010 || bus.out_data !== 64'h0000_0000_0000_0E00) begin failures++; $display("FAIL uf_pop1 got rd_en=%b data=%0h exp 0010/e00", bus.fifo_rd_en, bus.out_data); end
      @(negedge clk);
      checks++; if (bus.fifo_rd_en !== 4'd0 || bus.busy !== 1'b1 || bus.cur_idx !== 3'd1) begin failures++; $display("FAIL uf_stall_a got rd_en=%b busy=%0b cur_idx=%0d exp 0000/1/1", bus.fifo_rd_en, bus.busy, bus.cur_idx); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0000_0000_0000_0E01 || bus.out_last !== 1'b0) begin failures++; $display("FAIL uf_word1 got valid=%0b data=%0h last=%0b exp 1/e01/0", bus.out_valid, bus.out_data, bus.out_last); end
      @(negedge clk);
      checks++; if (bus.fifo_rd_en !== 4'd0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL uf_stall_b got rd_en=%b valid=%0b busy=%0b exp 0000/0/1", bus.fifo_rd_en, bus.out_valid, bus.busy); end
      push(1, 64'h0000_0000_0000_0E02, 1'b1);
      #1;
      checks++; if (bus.fifo_rd_en !== 4'b0010) begin failures++; $display("FAIL uf_resume got=%b exp=0010", bus.fifo_rd_en); end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0000_0000_0000_0E02 || bus.out_last !== 1'b1) begin failures++; $display("FAIL uf_last got valid=%0b data=%0h last=%0b exp 1/e02/1", bus.out_valid, bus.out_data, bus.out_last); end
   endtask

   task automatic test_long_event();
      apply_reset();
      pulse_eoe(0);
      for (int k = 0; k < 1025; k++) push(0, 64'h0000_0000_0001_0000 + 64'(k), 1'b0);
      bus.fifo_idx = 3'd0;
      @(negedge clk);
      bus.fifo_idx = 3'd4;
      repeat (1023) @(negedge clk);
      checks++; if (bus.err_long_evt !== 1'b0 || bus.out_data !== 64'h0000_0000_0001_03FE) begin failures++; $display("FAIL long_1023 got err=%0b data=%0h exp 0/103fe", bus.err_long_evt, bus.out_data); end
      @(negedge clk);
      checks++; if (bus.err_long_evt !== 1'b1 || bus.out_data !== 64'h0000_0000_0001_03FF) begin failures++; $display("FAIL long_1024 got err=%0b data=%0h exp 1/103ff", bus.err_long_evt, bus.out_data); end
      @(negedge clk);
      checks++; if (bus.err_long_evt !== 1'b1 || bus.busy !== 1'b1 || bus.cur_idx !== 3'd0 || bus.out_data !== 64'h0000_0000_0001_0400) begin failures++; $display("FAIL long_1025 got err=%0b busy=%0b cur_idx=%0d data=%0h exp 1/1/0/10400", bus.err_long_evt, bus.busy, bus.cur_idx, bus.out_data); end
   endtask

   task automatic test_reset_mid_stream();
      push(0, 64'h0000_0000_0000_DEAD, 1'b0);
      #1;
      checks++; if (bus.fifo_rd_en !== 4'b0001 || bus.evt_available !== 4'b0001) begin failures++; $display("FAIL rst_pre got rd_en=%b avail=%b exp 0001/0001", bus.fifo_rd_en, bus.evt_available); end
      #1;
      rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.fifo_rd_en !== 4'd0) begin failures++; $display("FAIL rst_async_out got valid=%0b rd_en=%b exp 0/0000", bus.out_valid, bus.fifo_rd_en); end
      checks++; if (bus.busy !== 1'b0 || bus.cur_idx !== 3'd4) begin failures++; $display("FAIL rst_async_state got busy=%0b cur_idx=%0d exp 0/4", bus.busy, bus.cur_idx); end
      checks++; if (bus.evt_available !== 4'd0 || bus.err_long_evt !== 1'b0) begin failures++; $display("FAIL rst_async_cnt got avail=%b err=%0b exp 0000/0", bus.evt_available, bus.err_long_evt); end
      for (int i = 0; i < 4; i++) wr_ptr[i] = 11'd0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.fifo_idx    = 3'd4;
      bus.fifo_wr_eoe = 4'd0;
      bus.out_ready   = 1'b1;
      for (int i = 0; i < 4; i++) wr_ptr[i] = 11'd0;
      test_reset();
      test_single_event();
      test_backpressure();
      test_no_selection();
      test_counter_edges();
      test_underflow();
      test_long_event();
      test_reset_mid_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
